// File: rtl/regfile_hilo_pkg.sv
// Shared types and constants for the MIPS-style GPR file with HI/LO registers.
package regfile_hilo_pkg;

    typedef logic [4:0]  creg_addr_t;
    typedef logic [31:0] word_t;

    localparam creg_addr_t REG_ZERO  = 5'd0;
    localparam word_t      WORD_ZERO = 32'h0;

endpackage

// File: rtl/hilo_reg.sv
// HI/LO multiply-divide result registers with same-cycle write bypass.
module hilo_reg
    import regfile_hilo_pkg::*;
(
    input  logic  clk,
    input  logic  resetn,
    input  logic  wr_ok,
    input  logic  hi_we,
    input  logic  lo_we,
    input  word_t hi_wd,
    input  word_t lo_wd,
    output word_t hi_rd,
    output word_t lo_rd
);

    word_t hi_q;
    word_t lo_q;
    logic  hi_wr;
    logic  lo_wr;

    // A write that will not commit is not bypassed either.
    assign hi_wr = hi_we & wr_ok & resetn;
    assign lo_wr = lo_we & wr_ok & resetn;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= WORD_ZERO;
            lo_q <= WORD_ZERO;
        end else begin
            if (hi_wr) hi_q <= hi_wd;
            if (lo_wr) lo_q <= lo_wd;
        end
    end

    always_comb begin
        hi_rd = hi_wr ? hi_wd : hi_q;
        lo_rd = lo_wr ? lo_wd : lo_q;
    end

endmodule

// File: rtl/regfile_hilo.sv
// 31-entry flop-based GPR file (r0 hardwired to zero), two combinational
// read ports with write bypass, plus the HI/LO register pair.
module regfile_hilo
    import regfile_hilo_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  creg_addr_t ra1,
    input  creg_addr_t ra2,
    output word_t      rd1,
    output word_t      rd2,
    input  logic       we,
    input  creg_addr_t wa,
    input  word_t      wd,
    input  logic       hi_we,
    input  logic       lo_we,
    input  word_t      hi_wd,
    input  word_t      lo_wd,
    output word_t      hi_rd,
    output word_t      lo_rd
);

    word_t gpr_q [31:1];
    logic  wr_ok_q;
    logic  gpr_we;

    // Cleared by reset, set by the first clock edge afterwards, so a write
    // presented on the release edge is dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ok_q <= 1'b0;
        end else begin
            wr_ok_q <= 1'b1;
        end
    end

    assign gpr_we = we & wr_ok_q & resetn & (wa != REG_ZERO);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 1; i < 32; i++) begin
                gpr_q[i] <= WORD_ZERO;
            end
        end else if (gpr_we) begin
            gpr_q[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = WORD_ZERO;
        rd2 = WORD_ZERO;
        if (resetn && (ra1 != REG_ZERO)) begin
            rd1 = (gpr_we && (wa == ra1)) ? wd : gpr_q[ra1];
        end
        if (resetn && (ra2 != REG_ZERO)) begin
            rd2 = (gpr_we && (wa == ra2)) ? wd : gpr_q[ra2];
        end
    end

    hilo_reg u_hilo_reg (
        .clk    (clk),
        .resetn (resetn),
        .wr_ok  (wr_ok_q),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .hi_wd  (hi_wd),
        .lo_wd  (lo_wd),
        .hi_rd  (hi_rd),
        .lo_rd  (lo_rd)
    );

endmodule
